// File: rtl/pcie_cq_cc_pkg.sv
// pcie_cq_cc_pkg: request/status codes, descriptor offsets and FSM encoding for the CQ/CC bridge
package pcie_cq_cc_pkg;
  localparam logic [3:0] REQ_MEMRD = 4'b0000;
  localparam logic [3:0] REQ_MEMWR = 4'b0001;
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;
  localparam int CQ_DWC = 64;
  localparam int CQ_TYPE = 75;
  localparam int CQ_RID = 80;
  localparam int CQ_TAG = 96;
  localparam int CQ_TC = 121;
  localparam int CQ_ATTR = 124;
  localparam int CQ_PAYLOAD = 128;
  localparam int CC_LA = 0;
  localparam int CC_BC = 16;
  localparam int CC_DWC = 32;
  localparam int CC_ST = 43;
  localparam int CC_RID = 48;
  localparam int CC_TAG = 64;
  localparam int CC_TC = 89;
  localparam int CC_ATTR = 92;
  typedef enum logic [2:0] {ST_IDLE, ST_MEM, ST_WAIT_ACK, ST_CPL, ST_DRAIN} state_t;
  function automatic logic [1:0] tz4(input logic [3:0] be);
    return be[0] ? 2'd0 : be[1] ? 2'd1 : be[2] ? 2'd2 : be[3] ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [1:0] lz4(input logic [3:0] be);
    return be[3] ? 2'd0 : be[2] ? 2'd1 : be[1] ? 2'd2 : be[0] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/pcie_cpl_bytecount.sv
// pcie_cpl_bytecount: completion byte_count and lower_addr from the request byte enables
module pcie_cpl_bytecount
  import pcie_cq_cc_pkg::*;
(
  input  logic [3:0]  first_be,
  input  logic [3:0]  last_be,
  input  logic [10:0] dw_count,
  input  logic [4:0]  addr,
  output logic [12:0] byte_count,
  output logic [6:0]  lower_addr
);
  logic [2:0] bc1;
  always_comb begin
    bc1 = (first_be[3] && first_be[0]) ? 3'd4 :
          ((first_be[3:2] == 2'b01 && first_be[0]) || (first_be[3] && first_be[1:0] == 2'b10)) ? 3'd3 :
          (first_be == 4'b0011 || first_be == 4'b0110 || first_be == 4'b1100) ? 3'd2 : 3'd1;
    byte_count = (dw_count == 11'd1) ? {10'd0, bc1} : 13'd8 - 13'(tz4(first_be)) - 13'(lz4(last_be));
    lower_addr = {addr, tz4(first_be)};
  end
endmodule

// File: rtl/pcie_cq_cc_mem_bridge.sv
// pcie_cq_cc_mem_bridge: turns host CQ MemRd/MemWr into single 64-bit memory accesses and CC completions
module pcie_cq_cc_mem_bridge
  import pcie_cq_cc_pkg::*;
#(
  parameter int C_BUS_DATA_WIDTH = 256,
  parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 32,
  parameter int C_ADDR_WIDTH = 24,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_ACK_TIMEOUT = 256
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [C_BUS_DATA_WIDTH-1:0] S_AXIS_CQ_TDATA,
  input  logic [84:0]                 S_AXIS_CQ_TUSER,
  input  logic                        S_AXIS_CQ_TLAST,
  input  logic [C_BUS_KEEP_WIDTH-1:0] S_AXIS_CQ_TKEEP,
  input  logic                        S_AXIS_CQ_TVALID,
  output logic [21:0]                 S_AXIS_CQ_TREADY,
  output logic [C_BUS_DATA_WIDTH-1:0] M_AXIS_CC_TDATA,
  output logic [32:0]                 M_AXIS_CC_TUSER,
  output logic                        M_AXIS_CC_TLAST,
  output logic [C_BUS_KEEP_WIDTH-1:0] M_AXIS_CC_TKEEP,
  output logic                        M_AXIS_CC_TVALID,
  input  logic [3:0]                  M_AXIS_CC_TREADY,
  output logic                        M_MEM_IFACE_EN,
  output logic [C_ADDR_WIDTH-1:0]     M_MEM_IFACE_ADDR,
  output logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DIN,
  output logic [C_DATA_WIDTH/8-1:0]   M_MEM_IFACE_WE,
  input  logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DOUT,
  input  logic                        M_MEM_IFACE_ACK,
  output logic [15:0]                 STAT_UR_CNT,
  output logic [15:0]                 STAT_TIMEOUT_CNT
);
  localparam int CW = $clog2(C_ACK_TIMEOUT + 1);
  state_t state, state_nx;
  logic [C_ADDR_WIDTH-1:2] addr_q;
  logic [10:0] dwc_q, c_dwc;
  logic [3:0] fbe_q, lbe_q, c_type;
  logic [15:0] rid_q, ur_cnt, to_cnt;
  logic [7:0] tag_q;
  logic [2:0] tc_q, attr_q, st_q, st_nx;
  logic [63:0] wdata_q, rdata_q, din, payload;
  logic [7:0] we;
  logic [CW-1:0] cnt;
  logic [95:0] cc_desc;
  logic [12:0] byte_count;
  logic [6:0] lower_addr;
  logic rd_q, last_q, supp, st_ld, cap, ur_inc, to_inc, cq_rdy, en, cc_vld, dwc2, sc;
  assign c_type = S_AXIS_CQ_TDATA[CQ_TYPE +: 4];
  assign c_dwc = S_AXIS_CQ_TDATA[CQ_DWC +: 11];
  assign supp = (c_type == REQ_MEMRD || c_type == REQ_MEMWR) &&
                (c_dwc == 11'd1 || (c_dwc == 11'd2 && !S_AXIS_CQ_TDATA[2]));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      ur_cnt <= '0;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      ur_cnt <= ur_cnt + 16'(ur_inc && ur_cnt != 16'hFFFF);
      to_cnt <= to_cnt + 16'(to_inc && to_cnt != 16'hFFFF);
    end
  end
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && S_AXIS_CQ_TVALID) begin
      addr_q <= S_AXIS_CQ_TDATA[C_ADDR_WIDTH-1:2];
      dwc_q <= c_dwc;
      rd_q <= c_type == REQ_MEMRD;
      last_q <= S_AXIS_CQ_TLAST;
      fbe_q <= S_AXIS_CQ_TUSER[3:0];
      lbe_q <= S_AXIS_CQ_TUSER[7:4];
      rid_q <= S_AXIS_CQ_TDATA[CQ_RID +: 16];
      tag_q <= S_AXIS_CQ_TDATA[CQ_TAG +: 8];
      tc_q <= S_AXIS_CQ_TDATA[CQ_TC +: 3];
      attr_q <= S_AXIS_CQ_TDATA[CQ_ATTR +: 3];
      wdata_q <= S_AXIS_CQ_TDATA[CQ_PAYLOAD +: 64];
    end
    if (st_ld) st_q <= st_nx;
    if (cap) rdata_q <= M_MEM_IFACE_DOUT;
    cnt <= state == ST_MEM ? CW'(1) : cnt + CW'(1);
  end
  always_comb begin
    state_nx = state;
    st_nx = CPL_SC;
    {st_ld, cap, ur_inc, to_inc, cq_rdy, en, cc_vld} = '0;
    case (state)
      ST_IDLE: begin
        cq_rdy = 1'b1;
        if (S_AXIS_CQ_TVALID) begin
          if (supp) state_nx = ST_MEM;
          else begin
            ur_inc = 1'b1;
            st_ld = c_type == REQ_MEMRD;
            st_nx = CPL_UR;
            state_nx = c_type == REQ_MEMRD ? ST_CPL : S_AXIS_CQ_TLAST ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_MEM, ST_WAIT_ACK: begin
        en = state == ST_MEM;
        if (M_MEM_IFACE_ACK) begin
          st_ld = rd_q;
          cap = rd_q;
          state_nx = rd_q ? ST_CPL : last_q ? ST_IDLE : ST_DRAIN;
        end else if (state == ST_WAIT_ACK && cnt == CW'(C_ACK_TIMEOUT)) begin
          to_inc = 1'b1;
          st_ld = rd_q;
          st_nx = CPL_CA;
          state_nx = rd_q ? ST_CPL : ST_IDLE;
        end else state_nx = ST_WAIT_ACK;
      end
      ST_CPL: begin
        cc_vld = 1'b1;
        if (M_AXIS_CC_TREADY[0]) state_nx = ST_IDLE;
      end
      ST_DRAIN: begin
        cq_rdy = 1'b1;
        if (S_AXIS_CQ_TVALID && S_AXIS_CQ_TLAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  pcie_cpl_bytecount u_bc (
    .first_be(fbe_q), .last_be(lbe_q), .dw_count(dwc_q), .addr(addr_q[6:2]),
    .byte_count(byte_count), .lower_addr(lower_addr)
  );
  assign dwc2 = dwc_q == 11'd2;
  assign sc = st_q == CPL_SC;
  assign din = dwc2 ? wdata_q : addr_q[2] ? {wdata_q[31:0], 32'd0} : {32'd0, wdata_q[31:0]};
  assign we = dwc2 ? {lbe_q, fbe_q} : addr_q[2] ? {fbe_q, 4'd0} : {4'd0, fbe_q};
  assign payload = !sc ? '0 : dwc2 ? rdata_q : {32'd0, addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]};
  always_comb begin
    cc_desc = '0;
    cc_desc[CC_LA +: 7] = lower_addr;
    cc_desc[CC_BC +: 13] = byte_count;
    cc_desc[CC_DWC +: 11] = sc ? dwc_q : 11'd0;
    cc_desc[CC_ST +: 3] = st_q;
    cc_desc[CC_RID +: 16] = rid_q;
    cc_desc[CC_TAG +: 8] = tag_q;
    cc_desc[CC_TC +: 3] = tc_q;
    cc_desc[CC_ATTR +: 3] = attr_q;
  end
  // RST gates TREADY so nothing is offered to the host while reset is held
  assign S_AXIS_CQ_TREADY = {22{cq_rdy & ~RST}};
  assign M_AXIS_CC_TDATA = cc_vld ? {{(C_BUS_DATA_WIDTH-160){1'b0}}, payload, cc_desc} : '0;
  assign M_AXIS_CC_TUSER = '0;
  assign M_AXIS_CC_TLAST = cc_vld;
  assign M_AXIS_CC_TKEEP = !cc_vld ? '0 : !sc ? C_BUS_KEEP_WIDTH'(8'h07) :
                           dwc2 ? C_BUS_KEEP_WIDTH'(8'h1F) : C_BUS_KEEP_WIDTH'(8'h0F);
  assign M_AXIS_CC_TVALID = cc_vld;
  assign M_MEM_IFACE_EN = en;
  assign M_MEM_IFACE_ADDR = en ? {addr_q[C_ADDR_WIDTH-1:3], 3'b000} : '0;
  assign M_MEM_IFACE_DIN = en && !rd_q ? din : '0;
  assign M_MEM_IFACE_WE = en && !rd_q ? we : '0;
  assign STAT_UR_CNT = ur_cnt;
  assign STAT_TIMEOUT_CNT = to_cnt;
  logic unused_ok;
  assign unused_ok = ^{S_AXIS_CQ_TDATA[1:0], S_AXIS_CQ_TDATA[63:C_ADDR_WIDTH], S_AXIS_CQ_TDATA[79],
                       S_AXIS_CQ_TDATA[120:104], S_AXIS_CQ_TDATA[127], S_AXIS_CQ_TDATA[C_BUS_DATA_WIDTH-1:192],
                       S_AXIS_CQ_TUSER[84:8], S_AXIS_CQ_TKEEP, M_AXIS_CC_TREADY[3:1]};
endmodule

// File: tb/tb_pcie_cq_cc_mem_bridge.sv
// tb_pcie_cq_cc_mem_bridge: directed vectors for the CQ/CC memory bridge with hand-computed expectations
module tb_pcie_cq_cc_mem_bridge;
  localparam int TO = 256;
  logic clk = 0, rst = 1;
  logic [255:0] cq_tdata = '0, cc_tdata;
  logic [84:0] cq_tuser = '0;
  logic cq_tlast = 0, cq_tvalid = 0;
  logic [7:0] cq_tkeep = 8'hFF, cc_tkeep;
  logic [21:0] cq_tready;
  logic [32:0] cc_tuser;
  logic cc_tlast, cc_tvalid;
  logic [3:0] cc_tready = 4'h1;
  logic en, ack = 0;
  logic [23:0] addr;
  logic [63:0] din, dout = '0;
  logic [7:0] we;
  logic [15:0] ur_cnt, to_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pcie_cq_cc_mem_bridge #(.C_ACK_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst),
    .S_AXIS_CQ_TDATA(cq_tdata), .S_AXIS_CQ_TUSER(cq_tuser), .S_AXIS_CQ_TLAST(cq_tlast),
    .S_AXIS_CQ_TKEEP(cq_tkeep), .S_AXIS_CQ_TVALID(cq_tvalid), .S_AXIS_CQ_TREADY(cq_tready),
    .M_AXIS_CC_TDATA(cc_tdata), .M_AXIS_CC_TUSER(cc_tuser), .M_AXIS_CC_TLAST(cc_tlast),
    .M_AXIS_CC_TKEEP(cc_tkeep), .M_AXIS_CC_TVALID(cc_tvalid), .M_AXIS_CC_TREADY(cc_tready),
    .M_MEM_IFACE_EN(en), .M_MEM_IFACE_ADDR(addr), .M_MEM_IFACE_DIN(din), .M_MEM_IFACE_WE(we),
    .M_MEM_IFACE_DOUT(dout), .M_MEM_IFACE_ACK(ack),
    .STAT_UR_CNT(ur_cnt), .STAT_TIMEOUT_CNT(to_cnt)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] cq(input logic [63:0] a, input logic [10:0] dwc, input logic [3:0] typ,
                                      input logic [7:0] tag, input logic [31:0] d4, input logic [31:0] d5);
    logic [255:0] v;
    v = '0;
    v[63:2] = a[63:2];
    v[74:64] = dwc;
    v[78:75] = typ;
    v[95:80] = 16'hBEEF;
    v[103:96] = tag;
    v[123:121] = 3'd5;
    v[126:124] = 3'd2;
    v[159:128] = d4;
    v[191:160] = d5;
    return v;
  endfunction
  function automatic logic [255:0] cc(input logic [6:0] la, input logic [12:0] bc, input logic [10:0] dwc,
                                      input logic [2:0] st, input logic [7:0] tag, input logic [63:0] pl);
    logic [255:0] v;
    v = '0;
    v[6:0] = la;
    v[28:16] = bc;
    v[42:32] = dwc;
    v[45:43] = st;
    v[63:48] = 16'hBEEF;
    v[71:64] = tag;
    v[91:89] = 3'd5;
    v[94:92] = 3'd2;
    v[159:96] = pl;
    return v;
  endfunction
  task automatic send(input logic [255:0] d, input logic [3:0] fbe, input logic [3:0] lbe, input logic last);
    cq_tdata = d;
    cq_tuser = {77'd0, lbe, fbe};
    cq_tlast = last;
    cq_tvalid = 1;
    step;
    cq_tvalid = 0;
  endtask
  initial begin
    step;
    step;
    check("rst_tready", cq_tready, 0);
    check("rst_en", en, 0);
    check("rst_ccvalid", cc_tvalid, 0);
    check("rst_cnts", {ur_cnt, to_cnt}, 0);
    rst = 0;
    #1;
    check("idle_tready", cq_tready, 22'h3FFFFF);
    // MemRd 1 DW at 0x204, ACK two cycles after EN
    send(cq(64'h204, 11'd1, 4'b0000, 8'h15, 0, 0), 4'hF, 4'h0, 1);
    check("rd1_en", en, 1);
    check("rd1_addr", addr, 24'h000200);
    check("rd1_we", we, 0);
    check("rd1_tready_busy", cq_tready, 0);
    step;
    check("rd1_en_once", en, 0);
    check("rd1_no_cc_yet", cc_tvalid, 0);
    step;
    ack = 1;
    dout = 64'hAABBCCDD_11223344;
    step;
    ack = 0;
    check("rd1_ccvalid", cc_tvalid, 1);
    check("rd1_cc", cc_tdata, cc(7'h04, 13'd4, 11'd1, 3'b000, 8'h15, 64'hAABBCCDD));
    check("rd1_keep", cc_tkeep, 8'h0F);
    check("rd1_last", cc_tlast, 1);
    step;
    check("rd1_done", cc_tvalid, 0);
    // MemWr 2 DW, ACK in the EN cycle
    send(cq(64'h300, 11'd2, 4'b0001, 8'h01, 32'h11111111, 32'h22222222), 4'hF, 4'h3, 1);
    check("wr2_en", en, 1);
    check("wr2_addr", addr, 24'h000300);
    check("wr2_din", din, 64'h22222222_11111111);
    check("wr2_we", we, 8'h3F);
    ack = 1;
    step;
    ack = 0;
    check("wr2_no_cc", cc_tvalid, 0);
    check("wr2_idle", cq_tready, 22'h3FFFFF);
    // MemWr 1 DW in the upper half
    send(cq(64'h104, 11'd1, 4'b0001, 8'h02, 32'hDEADBEEF, 0), 4'hC, 4'h0, 1);
    check("wr1_addr", addr, 24'h000100);
    check("wr1_din", din, 64'hDEADBEEF_00000000);
    check("wr1_we", we, 8'hC0);
    ack = 1;
    step;
    ack = 0;
    // MemRd 1 DW, first_be=0110
    send(cq(64'h008, 11'd1, 4'b0000, 8'h33, 0, 0), 4'b0110, 4'h0, 1);
    ack = 1;
    dout = 64'h55667788_99AABBCC;
    step;
    ack = 0;
    check("rd_be6_cc", cc_tdata, cc(7'h09, 13'd2, 11'd1, 3'b000, 8'h33, 64'h99AABBCC));
    step;
    // MemRd 2 DW
    send(cq(64'h010, 11'd2, 4'b0000, 8'h44, 0, 0), 4'hF, 4'h3, 1);
    ack = 1;
    dout = 64'h0BADCAFE_FEEDFACE;
    step;
    ack = 0;
    check("rd2_cc", cc_tdata, cc(7'h10, 13'd6, 11'd2, 3'b000, 8'h44, 64'h0BADCAFE_FEEDFACE));
    check("rd2_keep", cc_tkeep, 8'h1F);
    step;
    // MemRd never acknowledged
    cc_tready = 0;
    send(cq(64'h40C, 11'd1, 4'b0000, 8'h55, 0, 0), 4'hF, 4'h0, 1);
    for (int i = 0; i < TO; i++) step;
    check("to_not_yet", cc_tvalid, 0);
    step;
    check("to_ccvalid", cc_tvalid, 1);
    check("to_cc", cc_tdata, cc(7'h0C, 13'd4, 11'd0, 3'b100, 8'h55, 64'h0));
    check("to_keep", cc_tkeep, 8'h07);
    check("to_cnt", to_cnt, 1);
    cc_tready = 1;
    step;
    ack = 1;
    dout = 64'hFFFFFFFF_FFFFFFFF;
    step;
    ack = 0;
    check("late_ack_cc", cc_tvalid, 0);
    check("late_ack_en", en, 0);
    check("late_ack_cnt", to_cnt, 1);
    // Unsupported MemRd (4 DW) gets UR
    send(cq(64'h020, 11'd4, 4'b0000, 8'h66, 0, 0), 4'hF, 4'hF, 1);
    check("ur_ccvalid", cc_tvalid, 1);
    check("ur_en", en, 0);
    check("ur_status", cc_tdata[45:43], 3'b001);
    check("ur_dwc", cc_tdata[42:32], 0);
    check("ur_payload", cc_tdata[255:96], 0);
    check("ur_keep", cc_tkeep, 8'h07);
    check("ur_cnt1", ur_cnt, 1);
    step;
    // 3-beat MemWr with dw_count=16 is drained
    send(cq(64'h080, 11'd16, 4'b0001, 8'h77, 0, 0), 4'hF, 4'hF, 0);
    check("drain_en1", en, 0);
    check("drain_tready", cq_tready, 22'h3FFFFF);
    send(cq(64'h000, 11'd1, 4'b0000, 8'h78, 0, 0), 4'hF, 4'h0, 0);
    check("drain_en2", en, 0);
    send(cq(64'h000, 11'd1, 4'b0001, 8'h79, 0, 0), 4'hF, 4'h0, 1);
    check("drain_en3", en, 0);
    check("drain_cc", cc_tvalid, 0);
    check("ur_cnt2", ur_cnt, 2);
    step;
    check("drain_after", en, 0);
    // CC back-pressure, then reset mid-completion
    cc_tready = 0;
    send(cq(64'h018, 11'd1, 4'b0000, 8'h6A, 0, 0), 4'h3, 4'h0, 1);
    ack = 1;
    dout = 64'h01234567_89ABCDEF;
    step;
    ack = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", cc_tdata, cc(7'h18, 13'd2, 11'd1, 3'b000, 8'h6A, 64'h89ABCDEF));
      step;
    end
    check("bp_valid", cc_tvalid, 1);
    rst = 1;
    step;
    check("mid_rst_cc", {cc_tvalid, cc_tlast, cc_tkeep}, 0);
    check("mid_rst_data", cc_tdata, 0);
    check("mid_rst_tready", cq_tready, 0);
    check("mid_rst_cnts", {ur_cnt, to_cnt}, 0);
    rst = 0;
    cc_tready = 1;
    send(cq(64'h008, 11'd1, 4'b0001, 8'h01, 32'hCAFEF00D, 0), 4'hF, 4'h0, 1);
    check("post_rst_en", en, 1);
    check("post_rst_din", din, 64'h00000000_CAFEF00D);
    check("post_rst_we", we, 8'h0F);
    ack = 1;
    step;
    ack = 0;
    check("post_rst_idle", cq_tready, 22'h3FFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_cq_cc_mem_bridge.md
Name: pcie_cq_cc_mem_bridge

Overview:
PCIe completer-side bridge; the host-initiated counterpart of the DMA requester path. Accepts 256-bit CQ requests (host MemRd/MemWr to the BAR) and turns each one into a single access on the 64-bit memory interface (M_MEM_IFACE_*). That interface feeds the DMA engine register table and user registers. MemRd produces one CC completion beat carrying the returned data; MemWr produces no completion.

Parameters:
C_BUS_DATA_WIDTH, 256, CQ/CC data width; only 256 is supported.
C_BUS_KEEP_WIDTH, C_BUS_DATA_WIDTH/32, dword keep width.
C_ADDR_WIDTH, 24, memory-interface byte-address width.
C_DATA_WIDTH, 64, memory-interface data width; fixed at 64.
C_ACK_TIMEOUT, 256, maximum cycles to wait for ACK after EN.

Ports:
CLK  in  1  clock.
RST  in  1  reset; synchronous, active-high.
S_AXIS_CQ_TDATA  in  256  CQ descriptor [127:0] and payload from bit 128.
S_AXIS_CQ_TUSER  in  85  first_be [3:0], last_be [7:4].
S_AXIS_CQ_TLAST  in  1  last beat.
S_AXIS_CQ_TKEEP  in  8  dword keep.
S_AXIS_CQ_TVALID  in  1  request valid.
S_AXIS_CQ_TREADY  out  22  all bits identical.
M_AXIS_CC_TDATA  out  256  descriptor [95:0], payload from bit 96.
M_AXIS_CC_TUSER  out  33  tied 0.
M_AXIS_CC_TLAST  out  1  always 1 when valid.
M_AXIS_CC_TKEEP  out  8  dword keep.
M_AXIS_CC_TVALID  out  1  completion valid.
M_AXIS_CC_TREADY  in  4  only bit 0 is used.
M_MEM_IFACE_EN  out  1  one-cycle access strobe.
M_MEM_IFACE_ADDR  out  C_ADDR_WIDTH  byte address, bits [2:0]=0.
M_MEM_IFACE_DIN  out  64  write data.
M_MEM_IFACE_WE  out  8  byte write enables; 0 means read.
M_MEM_IFACE_DOUT  in  64  read data, valid with ACK.
M_MEM_IFACE_ACK  in  1  access done.
STAT_UR_CNT  out  16  saturating count of unsupported requests.
STAT_TIMEOUT_CNT  out  16  saturating count of ACK timeouts.

Behaviour:
- Reset: all outputs 0 (TREADY=0, CC_TVALID=0, EN=0, WE=0, counters=0); FSM goes to IDLE. Reset mid-access drops the pending access or completion; an ACK arriving after reset is ignored.
- CQ descriptor fields decoded: addr [63:2], dw_count [74:64], req_type [78:75], requester_id [95:80], tag [103:96], tc [123:121], attr [126:124].
- Supported request: req_type is 0000 (MemRd) or 0001 (MemWr), dw_count is 1 or 2, and a 2-DW request has addr[2]=0.
- FSM states: IDLE, MEM, WAIT_ACK, CPL, DRAIN.
- IDLE:
  - CQ_TREADY=1.
  - On a beat accepted at cycle T, latch the descriptor, BEs and payload dwords 4..5.
  - Supported request → MEM.
  - Unsupported MemRd → CPL with status UR (001), zero payload, STAT_UR_CNT+1.
  - Unsupported MemWr or any other type → dropped, STAT_UR_CNT+1; go to DRAIN if TLAST=0, else stay in IDLE.
- MEM (cycle T+1):
  - EN=1 for exactly one cycle; ADDR={addr[C_ADDR_WIDTH-1:3],3'b0}.
  - Write, 1 DW: addr[2]=0 puts payload in DIN[31:0] with WE[3:0]=first_be; addr[2]=1 puts it in DIN[63:32] with WE[7:4]=first_be.
  - Write, 2 DW: DIN={dw5,dw4}, WE={last_be,first_be}.
  - Read: WE=0.
  - Next state WAIT_ACK.
- WAIT_ACK:
  - ACK is sampled from the EN cycle onward.
  - Read: on ACK, capture DOUT → CPL.
  - Write: on ACK → IDLE (or DRAIN if the request beat was not last).
  - Timeout counter hits C_ACK_TIMEOUT → STAT_TIMEOUT_CNT+1. Read goes to CPL with status CA (100) and zero payload; write goes to IDLE.
  - A late ACK (after timeout) is ignored.
- CPL:
  - CC_TVALID=1 on the cycle after ACK; held stable until TREADY[0]; then → IDLE. CQ_TREADY=0 throughout.
  - Descriptor: lower_addr [6:0], byte_count [28:16], dword_count [42:32], status [45:43], requester_id [63:48], tag [71:64], completer_id 0, completer_id_en 0, tc [91:89], attr [94:92]; all other bits 0.
  - Payload: addr[2]=0 → DW3=DOUT[31:0], DW4=DOUT[63:32] (if 2 DW); addr[2]=1 → DW3=DOUT[63:32].
  - TKEEP: 0x07 for no payload, 0x0F for 1 DW, 0x1F for 2 DW. dword_count is 0 for UR/CA.
- byte_count:
  - 1 DW, by first_be: 1xx1→4; 01x1 or 1x10→3; 0011, 0110, 1100→2; otherwise 1 (including 0000).
  - 2 DW: 8 − tz(first_be) − lz(last_be).
- lower_addr = {addr[6:2], tz(first_be)[1:0]}, with tz(0000)=0.
- DRAIN: TREADY=1; discard beats until TLAST is accepted → IDLE.
- One request outstanding at a time; no CQ back-pressure is applied other than TREADY.

Decomposition:
- Package pcie_cq_cc_pkg: req_type codes (MEMRD=0000, MEMWR=0001), status codes (SC=000, UR=001, CA=100), descriptor bit offsets, FSM state encoding.
- Combinational sub-module pcie_cpl_bytecount: inputs first_be, last_be, dw_count, addr[6:2]; outputs byte_count and lower_addr.

Test Plan:
- MemRd, 1 DW, addr=0x000204, first_be=F, tag=0x15; ACK at T+3 with DOUT=0xAABBCCDD_11223344 → EN pulse at T+1 with ADDR=0x000200, WE=0; CC payload DW3=0xAABBCCDD, byte_count=4, lower_addr=0x04, tag=0x15, TKEEP=0x0F.
- MemWr, 2 DW, addr=0x000300, payload 0x11111111, 0x22222222, first_be=F, last_be=3 → DIN=0x22222222_11111111, WE=0x3F, no CC beat.
- MemRd, 1 DW, first_be=0110 → byte_count=2, lower_addr[1:0]=1.
- MemRd with no ACK → CC status CA at T+2+C_ACK_TIMEOUT; STAT_TIMEOUT_CNT=1; a later ACK causes no effect.
- MemRd, dw_count=4 → UR completion, TKEEP=0x07, no EN; a 3-beat MemWr with dw_count=16 is drained with no EN and STAT_UR_CNT=2.
- CC_TREADY held low 5 cycles, then RST pulsed mid-CPL → CC fields stable until reset, then all outputs 0 and a new request is accepted immediately after.
